// File: rtl/fifo_write_arbiter_pkg.sv
// Shared definitions for the async FIFO write side.
// Arbiter state encoding, default word width and counter sizing.
package fifo_write_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    localparam int FIFO_DSIZE = 8;

    // One extra bit so the burst counter can hold BURST itself.
    function automatic int cnt_width(input int burst);
        return $clog2(burst) + 1;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Requester/FIFO side bundle of the write arbiter.
// master = requesters plus FIFO flag, slave = arbiter.
interface fifo_write_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int DSIZE = 8
);
    logic [NREQ-1:0]       req;
    logic [NREQ*DSIZE-1:0] wdata_in;
    logic                  full;
    logic [NREQ-1:0]       ack;
    logic [NREQ-1:0]       grant;
    logic                  signal_write;
    logic [DSIZE-1:0]      wdata;
    logic                  busy;

    modport master (
        output req, wdata_in, full,
        input  ack, grant, signal_write, wdata, busy
    );

    modport slave (
        input  req, wdata_in, full,
        output ack, grant, signal_write, wdata, busy
    );
endinterface

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request above last.
// Shared with the read-side scheduler.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_last,
    output logic [NREQ-1:0] o_onehot,
    output logic [IW-1:0]   o_idx
);

    logic w_found;
    int   w_j;

    always_comb begin
        w_found  = 1'b0;
        w_j      = 0;
        o_onehot = '0;
        o_idx    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_j = (int'(i_last) + k) % NREQ;
            if (!w_found && i_req[w_j]) begin
                w_found       = 1'b1;
                o_onehot[w_j] = 1'b1;
                o_idx         = IW'(w_j);
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter owning the async FIFO write port on wclk.
// Bounded bursts per grant; writes are masked by the registered full flag.
module fifo_write_arbiter
    import fifo_write_arbiter_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int DSIZE = FIFO_DSIZE,
    parameter int BURST = 4
) (
    input  logic                 wclk,
    input  logic                 rst,
    fifo_write_arbiter_if.slave  bus
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = cnt_width(BURST);

    arb_state_t       r_state;
    arb_state_t       w_state_n;
    logic [NREQ-1:0]  r_grant;
    logic [NREQ-1:0]  w_grant_n;
    logic [NREQ-1:0]  w_pick;
    logic [IW-1:0]    r_last;
    logic [IW-1:0]    w_last_n;
    logic [IW-1:0]    r_gidx;
    logic [IW-1:0]    w_gidx_n;
    logic [IW-1:0]    w_pick_idx;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_n;
    logic             w_busy;
    logic             w_hold;
    logic             w_wr;
    logic [DSIZE-1:0] w_wdata;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .i_req    (bus.req),
        .i_last   (r_last),
        .o_onehot (w_pick),
        .o_idx    (w_pick_idx)
    );

    assign w_busy = (r_state == ARB_GRANT);
    assign w_hold = |(bus.req & r_grant);
    assign w_wr   = w_busy & w_hold & ~bus.full;

    assign bus.ack          = w_wr ? (bus.req & r_grant) : '0;
    assign bus.grant        = r_grant;
    assign bus.signal_write = w_wr;
    assign bus.wdata        = w_wdata;
    assign bus.busy         = w_busy;

    // Grant is all-zero when idle, so the mux yields zero then.
    always_comb begin
        w_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_grant[i]) begin
                w_wdata = bus.wdata_in[i*DSIZE +: DSIZE];
            end
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_grant_n = r_grant;
        w_gidx_n  = r_gidx;
        w_last_n  = r_last;
        w_cnt_n   = r_cnt;
        unique case (r_state)
            ARB_IDLE: begin
                if (|bus.req) begin
                    w_state_n = ARB_GRANT;
                    w_grant_n = w_pick;
                    w_gidx_n  = w_pick_idx;
                    w_cnt_n   = '0;
                end
            end
            ARB_GRANT: begin
                if (!w_hold) begin
                    w_state_n = ARB_IDLE;
                    w_grant_n = '0;
                    w_last_n  = r_gidx;
                end else if (w_wr) begin
                    w_cnt_n = r_cnt + CW'(1);
                    if (r_cnt == CW'(BURST - 1)) begin
                        w_state_n = ARB_IDLE;
                        w_grant_n = '0;
                        w_last_n  = r_gidx;
                    end
                end
            end
            default: begin
                w_state_n = ARB_IDLE;
                w_grant_n = '0;
            end
        endcase
    end

    always_ff @(posedge wclk or negedge rst) begin
        if (!rst) begin
            r_state <= ARB_IDLE;
            r_grant <= '0;
            r_gidx  <= '0;
            r_last  <= IW'(NREQ - 1);
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_n;
            r_grant <= w_grant_n;
            r_gidx  <= w_gidx_n;
            r_last  <= w_last_n;
            r_cnt   <= w_cnt_n;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: directed scenarios plus random traffic,
// all cycles scored against a transaction-level arbitration model.
module tb_fifo_write_arbiter;

    localparam int NREQ  = 4;
    localparam int DSIZE = 8;
    localparam int BURST = 4;

    typedef struct packed {
        logic [3:0] grant;
        logic       busy;
        logic       sw;
        logic [3:0] ack;
        logic [7:0] wdata;
    } exp_t;

    logic wclk = 1'b0;
    logic rst  = 1'b0;
    always #5 wclk = ~wclk;

    fifo_write_arbiter_if #(.NREQ(NREQ), .DSIZE(DSIZE)) bus ();
    fifo_write_arbiter_if #(.NREQ(NREQ), .DSIZE(DSIZE)) bus1 ();

    fifo_write_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .BURST(BURST)) dut (
        .wclk (wclk),
        .rst  (rst),
        .bus  (bus.slave)
    );

    fifo_write_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .BURST(1)) dut1 (
        .wclk (wclk),
        .rst  (rst),
        .bus  (bus1.slave)
    );

    int checks   = 0;
    int failures = 0;

    exp_t       exp_q[$];
    logic [7:0] pend[4][$];
    int         wr_log[$];
    logic       allow_wd = 1'b0;

    logic [3:0] s_grant, s_ack;
    logic       s_sw, s_busy;
    logic [7:0] s_wdata;

    // Reference model: owner of the port, words in current burst, last owner.
    int m_owner = -1;
    int m_n     = 0;
    int m_last  = NREQ - 1;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, got, expv);
        end
    endtask

    task automatic model_step(input logic [3:0] r, input logic f,
                              input logic [3:0][7:0] d, input logic rs);
        exp_t e;
        logic found;
        int   j;
        e = '0;
        found = 1'b0;
        if (!rs) begin
            m_owner = -1;
            m_n     = 0;
            m_last  = NREQ - 1;
        end else if (m_owner < 0) begin
            for (int k = 1; k <= NREQ; k++) begin
                j = (m_last + k) % NREQ;
                if (!found && r[j]) begin
                    found   = 1'b1;
                    m_owner = j;
                    m_n     = 0;
                end
            end
        end else begin
            e.grant = 4'(1 << m_owner);
            e.busy  = 1'b1;
            e.wdata = d[m_owner];
            if (!r[m_owner]) begin
                m_last  = m_owner;
                m_owner = -1;
            end else if (!f) begin
                e.sw  = 1'b1;
                e.ack = e.grant;
                m_n++;
                if (m_n == BURST) begin
                    m_last  = m_owner;
                    m_owner = -1;
                end
            end
        end
        exp_q.push_back(e);
    endtask

    // One clock of requester behaviour: each requester offers the head of
    // its pending queue and retires it when acknowledged.
    task automatic cycle(input logic f);
        logic [3:0]      r;
        logic [3:0][7:0] d;
        @(negedge wclk);
        for (int i = 0; i < NREQ; i++) begin
            r[i] = (pend[i].size() > 0);
            d[i] = r[i] ? pend[i][0] : 8'h00;
            if (allow_wd && r[i] && ($urandom % 16 == 0)) r[i] = 1'b0;
        end
        bus.req      = r;
        bus.wdata_in = d;
        bus.full     = f;
        #1;
        model_step(r, f, d, rst);
        #1;
        s_grant = bus.grant;
        s_ack   = bus.ack;
        s_sw    = bus.signal_write;
        s_busy  = bus.busy;
        s_wdata = bus.wdata;
        for (int i = 0; i < NREQ; i++) begin
            if (s_ack[i]) begin
                wr_log.push_back(i);
                if (pend[i].size() > 0) void'(pend[i].pop_front());
            end
        end
    endtask

    function automatic logic pend_any();
        for (int i = 0; i < NREQ; i++)
            if (pend[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drain(input string nm, input int bound);
        int n = 0;
        while (pend_any() && n < bound) begin
            cycle(1'b0);
            n++;
        end
        chk(nm, 32'(pend_any()), 0);
        cycle(1'b0);
        cycle(1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge wclk);
            #3;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_grant", 32'(bus.grant), 32'(e.grant));
                chk("sb_busy", 32'(bus.busy), 32'(e.busy));
                chk("sb_write", 32'(bus.signal_write), 32'(e.sw));
                chk("sb_ack", 32'(bus.ack), 32'(e.ack));
                chk("sb_wdata", 32'(bus.wdata), 32'(e.wdata));
            end
        end
    end

    initial begin
        int n;
        bus.req       = '0;
        bus.wdata_in  = '0;
        bus.full      = 1'b0;
        bus1.req      = '0;
        bus1.wdata_in = '0;
        bus1.full     = 1'b0;

        repeat (3) cycle(1'b0);
        chk("rst_grant", 32'(s_grant), 0);
        chk("rst_busy", 32'(s_busy), 0);
        rst = 1'b1;

        // Single requester, 6 words, BURST=4
        for (int k = 1; k <= 6; k++) pend[0].push_back(8'(8'hA0 + k));
        cycle(1'b0);
        chk("t1_idle_grant", 32'(s_grant), 0);
        cycle(1'b0);
        chk("t1_grant", 32'(s_grant), 4'b0001);
        chk("t1_first_write", 32'(s_sw), 1);
        chk("t1_first_data", 32'(s_wdata), 8'hA1);
        n = 2;
        while (pend[0].size() > 0 && n < 20) begin
            cycle(1'b0);
            n++;
        end
        chk("t1_cycles", n, 8);
        cycle(1'b0);
        cycle(1'b0);
        chk("t1_idle_after", 32'(s_busy), 0);

        // All four requesting continuously
        wr_log.delete();
        for (int i = 0; i < NREQ; i++)
            for (int k = 0; k < 8; k++) pend[i].push_back(8'(i * 16 + k));
        n = 0;
        while (pend_any() && n < 100) begin
            cycle(1'b0);
            n++;
        end
        chk("t2_cycles", n, 40);
        chk("t2_words", wr_log.size(), 32);
        for (int k = 0; k < wr_log.size() && k < 32; k++)
            chk("t2_order", wr_log[k], (1 + k / 4) % 4);
        cycle(1'b0);

        // Requester 2 stalled by full for 3 cycles mid-burst
        wr_log.delete();
        for (int k = 0; k < 4; k++) pend[2].push_back(8'(8'hC0 + k));
        cycle(1'b0);
        cycle(1'b0);
        chk("t3_grant", 32'(s_grant), 4'b0100);
        cycle(1'b0);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1);
            chk("t3_full_sw", 32'(s_sw), 0);
            chk("t3_full_ack", 32'(s_ack), 0);
            chk("t3_full_grant", 32'(s_grant), 4'b0100);
        end
        cycle(1'b0);
        chk("t3_resume", 32'(s_sw), 1);
        cycle(1'b0);
        chk("t3_last_data", 32'(s_wdata), 8'hC3);
        chk("t3_words", wr_log.size(), 4);
        cycle(1'b0);
        chk("t3_released", 32'(s_busy), 0);

        // Requester 1 drops after 2 acks
        pend[1].push_back(8'h51);
        pend[1].push_back(8'h52);
        cycle(1'b0);
        cycle(1'b0);
        chk("t4_grant", 32'(s_grant), 4'b0010);
        cycle(1'b0);
        cycle(1'b0);
        chk("t4_drop_grant", 32'(s_grant), 4'b0010);
        chk("t4_drop_sw", 32'(s_sw), 0);
        pend[0].push_back(8'h01);
        pend[0].push_back(8'h02);
        pend[2].push_back(8'h21);
        pend[2].push_back(8'h22);
        cycle(1'b0);
        chk("t4_released", 32'(s_busy), 0);
        cycle(1'b0);
        chk("t4_next_pick", 32'(s_grant), 4'b0100);
        drain("t4_drain", 30);

        // Asynchronous reset mid-burst
        for (int i = 0; i < NREQ; i++)
            for (int k = 0; k < 4; k++) pend[i].push_back(8'(8'h80 + i * 8 + k));
        cycle(1'b0);
        cycle(1'b0);
        cycle(1'b0);
        chk("t5_pre_busy", 32'(s_busy), 1);
        #5;
        rst = 1'b0;
        #1;
        chk("t5_rst_grant", 32'(bus.grant), 0);
        chk("t5_rst_busy", 32'(bus.busy), 0);
        chk("t5_rst_sw", 32'(bus.signal_write), 0);
        chk("t5_rst_ack", 32'(bus.ack), 0);
        chk("t5_rst_wdata", 32'(bus.wdata), 0);
        for (int i = 0; i < NREQ; i++) pend[i].delete();
        cycle(1'b0);
        cycle(1'b0);
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++)
            for (int k = 0; k < 2; k++) pend[i].push_back(8'(8'h90 + i * 8 + k));
        cycle(1'b0);
        cycle(1'b0);
        chk("t5_first_winner", 32'(s_grant), 4'b0001);
        drain("t5_drain", 40);

        // BURST=1 instance: requester 3 alone, one word per two cycles
        for (int k = 0; k < 10; k++) begin
            @(negedge wclk);
            bus1.req = 4'b1000;
            if (k == 0 || bus1.ack[3]) begin
                for (int i = 0; i < NREQ; i++)
                    bus1.wdata_in[i*8 +: 8] = 8'($urandom);
            end
            #2;
            chk("t6_sw", 32'(bus1.signal_write), 32'(k % 2));
            if (bus1.signal_write) begin
                chk("t6_wdata", 32'(bus1.wdata), 32'(bus1.wdata_in[31:24]));
                chk("t6_ack", 32'(bus1.ack), 4'b1000);
            end
            @(posedge wclk);
            if (bus1.ack[3] && k < 9) begin
                // ack already seen before the edge; data changes next cycle
            end
        end
        @(negedge wclk);
        bus1.req = '0;

        // Random traffic with stalls and withdrawals
        allow_wd = 1'b1;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (pend[i].size() == 0 && ($urandom % 3 == 0)) begin
                    n = 1 + int'($urandom % 3);
                    for (int k = 0; k < n; k++) pend[i].push_back(8'($urandom));
                end
            end
            cycle(($urandom % 4) == 0);
        end
        allow_wd = 1'b0;
        drain("t7_drain", 300);

        @(negedge wclk);
        #4;
        chk("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
